day03_result_printer: RTL and testbench
=======================================

DAY03_RESULT_PRINTER -- requirements
Module: day03_result_printer

Interface
REQ-001 SHALL have parameter N_BCD_DIGITS, default 20: decimal digits per converted value, sized to cover a 64-bit unsigned value.
REQ-002 SHALL have ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- part1_result, input, 64: unsigned part-1 total from the solver core.
- part2_result, input, 64: unsigned part-2 total from the solver core.
- done, input, 1: solver results valid; level, sticky upstream.
- out_data, output, 8: ASCII byte.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: sink accepts out_data.
- fmt_done, output, 1: all bytes transferred; sticky.

Function
REQ-003 SHALL implement states IDLE, CONV, SCAN, EMIT, NL and FIN.
REQ-004 IDLE: the edge sampling done=1 SHALL latch part1_result and part2_result, select part 1, and enter CONV.
REQ-005 CONV SHALL run serial double-dabble, exactly 64 shift cycles, with an N_BCD_DIGITS*4-bit BCD register (add 3 to each nibble >=5 before each shift), then enter SCAN.
REQ-006 SCAN SHALL, in one cycle, priority-encode the index of the most significant non-zero digit (index 0 if value is 0), then enter EMIT.
REQ-007 For a given done-sampling edge k, out_valid SHALL first rise after edge k+65 (64 CONV plus 1 SCAN).
REQ-008 EMIT SHALL output digits MSB-first from that index as "0"+digit; leading zeros are never emitted, and value 0 emits the single byte "0".
REQ-009 NL SHALL emit 8'h0A; on its transfer with part 1 selected, SHALL select part 2 and re-enter CONV; with part 2 selected, SHALL enter FIN.
REQ-010 Handshake: a transfer occurs on an edge with out_valid&&out_ready; while out_valid=1 and out_ready=0, out_data SHALL stay stable and out_valid SHALL stay high.
REQ-011 out_valid SHALL be 0 in IDLE, CONV, SCAN and FIN; throughput SHALL be one byte per cycle when out_ready=1.
REQ-012 FIN SHALL hold fmt_done=1 until reset; done is ignored there.
REQ-013 done deasserting after the latch SHALL NOT affect the sequence; result inputs changing after the latch SHALL be ignored.
REQ-014 Output byte count SHALL equal (digits1+1)+(digits2+1), plus prefixes when enabled.

Reset
REQ-015 rst_n=0 SHALL immediately force state=IDLE, out_valid=0, out_data=0, fmt_done=0, and clear the latched values and BCD register, including mid-CONV or mid-EMIT.
REQ-016 After reset release, operation SHALL restart only on a fresh done=1 sample.

Configuration
REQ-017 With macro DAY03_RESULT_PREFIX_EN defined, a PFX state SHALL precede each CONV, emitting "P1: " or "P2: " (4 bytes, same handshake).
- The first-out_valid latency in REQ-007 then refers to the first prefix byte, which rises one cycle after the latch.
- The digit bytes follow the prefix after the 65-cycle conversion.
REQ-018 Without DAY03_RESULT_PREFIX_EN, there SHALL be no PFX state and no prefix logic.

Structure
REQ-019 Shared package day03_fmt_pkg SHALL hold the state enum, the ASCII constants ("0", LF, "P", "1", "2", ":", space), and the default N_BCD_DIGITS.
REQ-020 Sub-module bin2bcd_serial (start, 64-bit bin in, busy/done, BCD out) SHALL perform the double-dabble, instantiated once and reused for both parts.

Verification
REQ-021 Benches SHALL cover these directed scenarios:
- p1=357, p2=3121910778619, out_ready=1: stream "357\n3121910778619\n"; fmt_done=1; first out_valid after edge k+65.
- p1=0, p2=0: stream "0\n0\n", exactly 4 bytes.
- p1=p2=64'hFFFF_FFFF_FFFF_FFFF: each line is "18446744073709551615\n" (20 digits).
- p1=98, p2=987654321111 with out_ready toggling 1-0-0-1 repeatedly: out_data stable across stalls; byte sequence identical to the no-stall case.
- rst_n pulsed low during the 3rd digit of part 2: outputs zero immediately; after release and done=1, the full stream is re-emitted from the start.
- DAY03_RESULT_PREFIX_EN defined, p1=357, p2=17: stream "P1: 357\nP2: 17\n".

Source files
------------

// File: rtl/day03_fmt_pkg.sv
// Shared state encoding, ASCII constants and default sizing for the day-03 result printer.
// Latency: none, this file only holds declarations.
// Backpressure: none, this file only holds declarations.
// The optional ST_PFX state exists only when DAY03_RESULT_PREFIX_EN is defined.
package day03_fmt_pkg;

    // 20 decimal digits are enough for 2^64-1 = 18446744073709551615
    localparam int DEF_N_BCD_DIGITS = 20;
    localparam int BIN_W            = 64;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_P     = 8'h50;
    localparam logic [7:0] ASC_1     = 8'h31;
    localparam logic [7:0] ASC_2     = 8'h32;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_SP    = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_SCAN,
        ST_EMIT,
        ST_NL,
`ifdef DAY03_RESULT_PREFIX_EN
        ST_FIN,
        ST_PFX
`else
        ST_FIN
`endif
    } state_t;

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: a 64-bit unsigned value becomes N_DIGITS packed BCD nibbles.
// Latency: 64 cycles after start; done is high during the cycle whose edge makes the last shift.
// Backpressure: none; start is only issued while idle, and bcd holds its value until the next start.
module bin2bcd_serial
    import day03_fmt_pkg::*;
#(
    parameter int N_DIGITS = DEF_N_BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [N_DIGITS*4-1:0] bcd
);

    localparam int BW = N_DIGITS * 4;

    logic [BIN_W-1:0] sh_q;
    logic [6:0]       cnt_q;
    logic [BW-1:0]    adj;

    // Add 3 to every nibble that is 5 or more, so the next shift carries correctly into the next digit
    always_comb begin
        adj = bcd;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then shift one binary bit into the adjusted BCD register per cycle for 64 cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            bcd   <= '0;
        end else if (start) begin
            sh_q  <= bin;
            cnt_q <= 7'd64;
            busy  <= 1'b1;
            bcd   <= '0;
        end else if (busy) begin
            bcd   <= {adj[BW-2:0], sh_q[BIN_W-1]};
            sh_q  <= {sh_q[BIN_W-2:0], 1'b0};
            cnt_q <= cnt_q - 7'd1;
            if (cnt_q == 7'd1) begin
                busy <= 1'b0;
            end
        end
    end

    assign done = busy && (cnt_q == 7'd1);

endmodule

// File: rtl/day03_result_printer.sv
// Prints the part-1 and part-2 totals as decimal ASCII lines. Each line is one value followed by LF.
// Latency: the first byte is valid after edge k+65 (k is the edge that samples done), or after edge k when DAY03_RESULT_PREFIX_EN is defined.
// Backpressure: valid/ready; out_data is held while out_ready=0; one byte per cycle when out_ready=1.
module day03_result_printer
    import day03_fmt_pkg::*;
#(
    parameter int N_BCD_DIGITS = DEF_N_BCD_DIGITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] part1_result,
    input  logic [BIN_W-1:0] part2_result,
    input  logic             done,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             fmt_done
);

    localparam int IW = (N_BCD_DIGITS > 1) ? $clog2(N_BCD_DIGITS) : 1;

    state_t                  state_q, state_d;
    logic                    sel_p2;
    logic [IW-1:0]           dig_q;
    logic [IW-1:0]           msd;
    logic [3:0]              cur_nib;
    logic [BIN_W-1:0]        p2_q;
    logic [BIN_W-1:0]        cvt_bin;
    logic                    start_req;
    logic                    cvt_start;
    logic                    cvt_busy;
    logic                    cvt_done;
    logic [N_BCD_DIGITS*4-1:0] cvt_bcd;
`ifdef DAY03_RESULT_PREFIX_EN
    logic [BIN_W-1:0]        p1_q;
    logic [1:0]              pfx_idx;
`endif

    bin2bcd_serial #(
        .N_DIGITS (N_BCD_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (cvt_start),
        .bin   (cvt_bin),
        .busy  (cvt_busy),
        .done  (cvt_done),
        .bcd   (cvt_bcd)
    );

`ifdef DAY03_RESULT_PREFIX_EN
    // Conversion starts after the prefix, so both parts come from the latched copies
    assign cvt_bin = sel_p2 ? p2_q : p1_q;
`else
    // Part 1 starts converting on the latch edge itself, so the shift register captures the live input.
    // Part 2 always comes from the latched copy.
    assign cvt_bin = (state_q == ST_IDLE) ? part1_result : p2_q;
`endif

    assign cvt_start = start_req && !cvt_busy;

    // Priority-encode the most significant non-zero digit; a value of zero gives index 0
    always_comb begin
        msd = '0;
        for (int i = 0; i < N_BCD_DIGITS; i++) begin
            if (cvt_bcd[i*4 +: 4] != 4'd0) begin
                msd = IW'(i);
            end
        end
    end

    // Select the digit currently being emitted
    always_comb begin
        cur_nib = '0;
        for (int i = 0; i < N_BCD_DIGITS; i++) begin
            if (dig_q == IW'(i)) begin
                cur_nib = cvt_bcd[i*4 +: 4];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every byte-emitting state advances only on a completed transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (done) begin
`ifdef DAY03_RESULT_PREFIX_EN
                    state_d = ST_PFX;
`else
                    state_d = ST_CONV;
`endif
                end
            end
            ST_CONV: if (cvt_done) state_d = ST_SCAN;
            ST_SCAN: state_d = ST_EMIT;
            ST_EMIT: if (out_ready && (dig_q == '0)) state_d = ST_NL;
            ST_NL: begin
                if (out_ready) begin
                    if (sel_p2) begin
                        state_d = ST_FIN;
                    end else begin
`ifdef DAY03_RESULT_PREFIX_EN
                        state_d = ST_PFX;
`else
                        state_d = ST_CONV;
`endif
                    end
                end
            end
`ifdef DAY03_RESULT_PREFIX_EN
            ST_PFX: if (out_ready && (pfx_idx == 2'd3)) state_d = ST_CONV;
`endif
            ST_FIN: state_d = ST_FIN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and converter start, decoded from the current state
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        fmt_done  = 1'b0;
        start_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
`ifndef DAY03_RESULT_PREFIX_EN
                start_req = done;
`endif
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                out_data  = ASC_0 + {4'h0, cur_nib};
            end
            ST_NL: begin
                out_valid = 1'b1;
                out_data  = ASC_LF;
`ifndef DAY03_RESULT_PREFIX_EN
                start_req = out_ready && !sel_p2;
`endif
            end
`ifdef DAY03_RESULT_PREFIX_EN
            ST_PFX: begin
                out_valid = 1'b1;
                case (pfx_idx)
                    2'd0:    out_data = ASC_P;
                    2'd1:    out_data = sel_p2 ? ASC_2 : ASC_1;
                    2'd2:    out_data = ASC_COLON;
                    default: out_data = ASC_SP;
                endcase
                start_req = out_ready && (pfx_idx == 2'd3);
            end
`endif
            ST_FIN: fmt_done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: latch the inputs, track which part is selected, and step the digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p2_q    <= '0;
            sel_p2  <= 1'b0;
            dig_q   <= '0;
`ifdef DAY03_RESULT_PREFIX_EN
            p1_q    <= '0;
            pfx_idx <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (done) begin
                        p2_q   <= part2_result;
                        sel_p2 <= 1'b0;
`ifdef DAY03_RESULT_PREFIX_EN
                        p1_q    <= part1_result;
                        pfx_idx <= '0;
`endif
                    end
                end
                ST_SCAN: dig_q <= msd;
                ST_EMIT: if (out_ready && (dig_q != '0)) dig_q <= dig_q - IW'(1);
                ST_NL:   if (out_ready && !sel_p2) sel_p2 <= 1'b1;
`ifdef DAY03_RESULT_PREFIX_EN
                ST_PFX:  if (out_ready) pfx_idx <= pfx_idx + 2'd1;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_day03_result_printer.sv
// Directed bench for day03_result_printer: a vector table plus hand-written reset and stall sequences.
// Latency: it checks that the first out_valid arrives at the expected edge after the done sample.
// Backpressure: out_ready is either held high or driven with a repeating 1-0-0-1 pattern.
module tb_day03_result_printer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] part1_result;
    logic [63:0] part2_result;
    logic        done;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        fmt_done;

    day03_result_printer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .part1_result (part1_result),
        .part2_result (part2_result),
        .done         (done),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fmt_done     (fmt_done)
    );

    always #5 clk = ~clk;

`ifdef DAY03_RESULT_PREFIX_EN
    localparam int EXP_LAT = 0;
    localparam int MID_N   = 14;
    string p1s = "P1: ";
    string p2s = "P2: ";
`else
    localparam int EXP_LAT = 65;
    localparam int MID_N   = 6;
    string p1s = "";
    string p2s = "";
`endif

    typedef struct {
        logic [63:0] p1;
        logic [63:0] p2;
        bit          stall;
        string       stream;
    } vec_t;

    vec_t        vecs[5];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  cap[$];
    int          first_cyc = -1;
    bit          stall_en = 1'b0;
    bit          pat[4];
    int          pidx = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    always @(posedge clk) cyc++;

    // Ready driver, updated 2 time units after each rising edge
    initial begin
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (stall_en) begin
                out_ready = pat[pidx];
                pidx = (pidx + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
        end
    endtask

    // Sample on the falling edge: record transfers, first valid and stall stability
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("stall_hold_valid", {63'd0, out_valid}, 64'd1);
                check("stall_hold_data", {56'd0, out_data}, {56'd0, prev_data});
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (out_valid && out_ready) cap.push_back(out_data);
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic run_vec(input vec_t v, input string nm, input bit with_reset);
        int k;
        int t;
        int n;
        if (with_reset) do_reset();
        stall_en     = v.stall;
        part1_result = v.p1;
        part2_result = v.p2;
        cap.delete();
        first_cyc    = -1;
        @(posedge clk);
        #2;
        done = 1'b1;
        k    = cyc + 1;
        @(posedge clk);
        #2;
        // After the latch edge, later input changes and done falling must not matter
        done         = 1'b0;
        part1_result = ~v.p1;
        part2_result = 64'h1234_5678;
        t = 0;
        while (!fmt_done && t < 4000) begin
            @(posedge clk);
            #2;
            t++;
        end
        stall_en = 1'b0;
        check({nm, " finished_in_time"}, {63'd0, (t < 4000)}, 64'd1);
        check({nm, " first_valid_latency"}, 64'(first_cyc - k), 64'(EXP_LAT));
        check({nm, " byte_count"}, 64'(cap.size()), 64'(v.stream.len()));
        for (int i = 0; i < v.stream.len() && i < cap.size(); i++) begin
            check($sformatf("%s byte%0d", nm, i), {56'd0, cap[i]}, {56'd0, v.stream[i]});
        end
        // In FIN, fmt_done stays high and done is ignored
        n = cap.size();
        done = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        done = 1'b0;
        check({nm, " fmt_done_sticky"}, {63'd0, fmt_done}, 64'd1);
        check({nm, " fin_no_valid"}, {63'd0, out_valid}, 64'd0);
        check({nm, " fin_no_extra_bytes"}, 64'(cap.size()), 64'(n));
    endtask

    initial begin
        int t;
        vecs[0] = '{p1: 64'd357, p2: 64'd3121910778619, stall: 1'b0,
                    stream: {p1s, "357\n", p2s, "3121910778619\n"}};
        vecs[1] = '{p1: 64'd0, p2: 64'd0, stall: 1'b0,
                    stream: {p1s, "0\n", p2s, "0\n"}};
        vecs[2] = '{p1: 64'hFFFF_FFFF_FFFF_FFFF, p2: 64'hFFFF_FFFF_FFFF_FFFF, stall: 1'b0,
                    stream: {p1s, "18446744073709551615\n", p2s, "18446744073709551615\n"}};
        vecs[3] = '{p1: 64'd98, p2: 64'd987654321111, stall: 1'b1,
                    stream: {p1s, "98\n", p2s, "987654321111\n"}};
        vecs[4] = '{p1: 64'd357, p2: 64'd17, stall: 1'b0,
                    stream: {p1s, "357\n", p2s, "17\n"}};

        // Reset state
        rst_n = 1'b0;
        done = 1'b0;
        part1_result = 64'd5;
        part2_result = 64'd7;
        #1;
        check("reset_valid", {63'd0, out_valid}, 64'd0);
        check("reset_data", {56'd0, out_data}, 64'd0);
        check("reset_fmt_done", {63'd0, fmt_done}, 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("idle_without_done", {62'd0, out_valid, fmt_done}, 64'd0);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);
        end

        // Reset while the 3rd digit of part 2 is on the output
        do_reset();
        cap.delete();
        part1_result = 64'd357;
        part2_result = 64'd3121910778619;
        @(posedge clk);
        #2;
        done = 1'b1;
        t = 0;
        while (cap.size() < MID_N && t < 2000) begin
            @(posedge clk);
            #3;
            t++;
        end
        check("mid_reached_digit3", {63'd0, (t < 2000)}, 64'd1);
        check("mid_digit3_value", {56'd0, out_data}, 64'h32);
        rst_n = 1'b0;
        done = 1'b0;
        #1;
        check("mid_reset_valid", {63'd0, out_valid}, 64'd0);
        check("mid_reset_data", {56'd0, out_data}, 64'd0);
        check("mid_reset_fmt_done", {63'd0, fmt_done}, 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cap.delete();
        repeat (6) @(posedge clk);
        #2;
        check("mid_no_restart_without_done", {63'd0, out_valid}, 64'd0);
        check("mid_no_bytes_without_done", 64'(cap.size()), 64'd0);
        run_vec(vecs[0], "after_reset", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
